// File: rtl/subservient_stream_sim.sv
// Simulation stand-in for the Subservient SoC: streams a preloaded byte memory as 8N1 serial on q.
// Optional build macro STREAM_LOOP_EN: after the terminator, idle 1024 clocks and replay the stream.
module subservient_stream_sim #(
  parameter string memfile     = "",
  parameter int    memsize     = 8192,
  parameter int    with_csr    = 0,
  parameter int    clk_freq_hz = 100000000,
  parameter int    baud        = 57600
) (
  input  logic wb_clk,
  input  logic wb_rst,
  output logic q
);

  localparam int              AW          = (memsize > 1) ? $clog2(memsize) : 1;
  localparam logic [15:0]     DIV_DEFAULT = 16'(clk_freq_hz / baud);
  localparam logic [AW-1:0]   START_ADDR  = (with_csr != 0) ? AW'(2) : {AW{1'b0}};
  localparam logic [AW-1:0]   LAST_ADDR   = AW'(memsize - 1);

  typedef enum logic [2:0] {
    CSR0  = 3'd0,
    CSR1  = 3'd1,
    FETCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    DONE  = 3'd6
  } state_t;

  logic [7:0]    mem [memsize];
  logic [7:0]    rdata_r;
  logic [AW-1:0] rd_addr_s;

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [15:0]   div_r;
  logic [15:0]   baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          primed_r;
`ifdef STREAM_LOOP_EN
  logic [9:0]    loop_cnt_r;
`endif

  // Time-zero memory image; contents survive wb_rst.
  initial begin
    for (int i = 0; i < memsize; i++) mem[i] = 8'h00;
  end

  // Read address: the state presenting it is one cycle ahead of the state consuming the data.
  always_comb begin
    rd_addr_s = addr_r;
    case (state_r)
      CSR0:    rd_addr_s = primed_r ? AW'(1) : {AW{1'b0}};
      CSR1:    rd_addr_s = START_ADDR;
      STOP: begin
        if (baud_cnt_r == 16'd0 && addr_r != LAST_ADDR) rd_addr_s = addr_r + AW'(1);
        else rd_addr_s = addr_r;
      end
      DONE:    rd_addr_s = START_ADDR;
      default: rd_addr_s = addr_r;
    endcase
  end

  // Synchronous memory read port.
  always_ff @(posedge wb_clk) begin
    rdata_r <= mem[rd_addr_s];
  end

  // Stream sequencer: header load, fetch, and 8N1 framing with div clocks per bit.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_r    <= (with_csr != 0) ? CSR0 : FETCH;
      q          <= 1'b1;
      addr_r     <= {AW{1'b0}};
      div_r      <= DIV_DEFAULT;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      primed_r   <= 1'b0;
`ifdef STREAM_LOOP_EN
      loop_cnt_r <= 10'd0;
`endif
    end else begin
      case (state_r)
        CSR0: begin
          if (!primed_r) begin
            primed_r <= 1'b1;
          end else begin
            div_r[7:0] <= rdata_r;
            state_r    <= CSR1;
          end
        end
        CSR1: begin
          if ({rdata_r, div_r[7:0]} < 16'd2) div_r <= DIV_DEFAULT;
          else div_r[15:8] <= rdata_r;
          addr_r  <= START_ADDR;
          state_r <= FETCH;
        end
        FETCH: begin
          // The first fetch after reset only primes the read pipeline.
          if (!primed_r) begin
            primed_r <= 1'b1;
          end else if (rdata_r == 8'h00) begin
            state_r <= DONE;
          end else begin
            shift_r    <= rdata_r;
            q          <= 1'b0;
            baud_cnt_r <= div_r - 16'd1;
            state_r    <= START;
          end
        end
        START: begin
          if (baud_cnt_r == 16'd0) begin
            q          <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= div_r - 16'd1;
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt_r == 16'd0) begin
            baud_cnt_r <= div_r - 16'd1;
            if (bit_cnt_r == 3'd7) begin
              q       <= 1'b1;
              state_r <= STOP;
            end else begin
              q         <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt_r == 16'd0) begin
            if (addr_r == LAST_ADDR) begin
              state_r <= DONE;
            end else begin
              addr_r  <= addr_r + AW'(1);
              state_r <= FETCH;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        DONE: begin
`ifdef STREAM_LOOP_EN
          if (loop_cnt_r == 10'd1023) begin
            loop_cnt_r <= 10'd0;
            addr_r     <= START_ADDR;
            state_r    <= FETCH;
          end else begin
            loop_cnt_r <= loop_cnt_r + 10'd1;
          end
`else
          state_r <= DONE;
`endif
        end
        default: begin
          state_r <= FETCH;
          q       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_stream_sim.sv
// Directed bench for subservient_stream_sim: several instances run in parallel, each preloaded
// through the hierarchy while held in reset, with 8N1 frames checked cycle by cycle.
module tb_subservient_stream_sim;

  logic       clk = 1'b0;
  logic       rst_a, rst_h, rst_s, rst_c, rst_e;
  logic [4:0] q_bus;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         empty_lows = 0;

  always #5 clk = ~clk;

  subservient_stream_sim u_a (.wb_clk(clk), .wb_rst(rst_a), .q(q_bus[0]));
  subservient_stream_sim u_hi (.wb_clk(clk), .wb_rst(rst_h), .q(q_bus[1]));
  subservient_stream_sim #(.memsize(4), .clk_freq_hz(460800)) u_small (.wb_clk(clk), .wb_rst(rst_s), .q(q_bus[2]));
  subservient_stream_sim #(.with_csr(1)) u_csr (.wb_clk(clk), .wb_rst(rst_c), .q(q_bus[3]));
  subservient_stream_sim u_empty (.wb_clk(clk), .wb_rst(rst_e), .q(q_bus[4]));

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input int idx, input int limit, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < limit) begin
      @(negedge clk);
      if (q_bus[idx] == 1'b0) found = 1'b1;
      else n++;
    end
  endtask

  // Waits for a start bit, then checks every bit level for exactly div clocks.
  task automatic recv(input int idx, input int div, input string tag, input logic [7:0] exp_byte,
                      output int gap);
    bit         found;
    int         good;
    logic [9:0] frame;
    logic [9:0] mid;
    wait_low(idx, 40000, gap, found);
    check_val({tag, " start"}, found, 1);
    if (found) begin
      frame = {1'b1, exp_byte, 1'b0};
      mid   = 10'h000;
      for (int b = 0; b < 10; b++) begin
        good = 0;
        for (int c = 0; c < div; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (c == div / 2) mid[b] = q_bus[idx];
          if (q_bus[idx] == frame[b]) good++;
        end
        check_val($sformatf("%s bit%0d", tag, b), good, div);
      end
      check_val({tag, " byte"}, mid[8:1], exp_byte);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_e && q_bus[4] == 1'b0) empty_lows++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_h = 1'b1; rst_s = 1'b1; rst_c = 1'b1; rst_e = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset q all", q_bus, 5'h1f);
    u_a.mem[0] = 8'h41; u_a.mem[1] = 8'h00;
    u_hi.mem[0] = 8'h48; u_hi.mem[1] = 8'h69; u_hi.mem[2] = 8'h0A; u_hi.mem[3] = 8'h00;
    u_small.mem[0] = 8'h31; u_small.mem[1] = 8'h32; u_small.mem[2] = 8'h33; u_small.mem[3] = 8'h34;
    u_csr.mem[0] = 8'h10; u_csr.mem[1] = 8'h00; u_csr.mem[2] = 8'h5A; u_csr.mem[3] = 8'h00;
    @(negedge clk);
    rst_a = 1'b0; rst_h = 1'b0; rst_s = 1'b0; rst_c = 1'b0; rst_e = 1'b0;
    fork
      begin : thread_a
        int gap; int n; bit found;
        @(posedge clk); #1 check_val("a edge1 q", q_bus[0], 1);
        @(posedge clk); #1 check_val("a edge2 q", q_bus[0], 0);
        recv(0, 1736, "a1", 8'h41, gap);
        check_val("a1 gap", gap, 0);
`ifdef STREAM_LOOP_EN
        recv(0, 1736, "a loop", 8'h41, gap);
        check_val("a loop gap", gap, 1026);
`else
        wait_low(0, 3000, n, found);
        check_val("a idle after done", found, 0);
`endif
        @(negedge clk) rst_a = 1'b1;
        @(negedge clk) rst_a = 1'b0;
        wait_low(0, 10, n, found);
        check_val("a restart found", found, 1);
        check_val("a restart edges", n, 1);
        repeat (4 * 1736 + 868) @(negedge clk);
        check_val("a bit3 low", q_bus[0], 0);
        #1 rst_a = 1'b1;
        #1 check_val("a async reset q", q_bus[0], 1);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        recv(0, 1736, "a2", 8'h41, gap);
        check_val("a2 gap", gap, 1);
      end
      begin : thread_hi
        int gap; int n; bit found;
        recv(1, 1736, "h0", 8'h48, gap);
        recv(1, 1736, "h1", 8'h69, gap);
        check_val("h1 gap", gap, 1);
        recv(1, 1736, "h2", 8'h0A, gap);
        check_val("h2 gap", gap, 1);
`ifndef STREAM_LOOP_EN
        wait_low(1, 2000, n, found);
        check_val("h idle after done", found, 0);
`endif
      end
      begin : thread_small
        int gap; int n; bit found;
        recv(2, 8, "s0", 8'h31, gap);
        recv(2, 8, "s1", 8'h32, gap);
        check_val("s1 gap", gap, 1);
        recv(2, 8, "s2", 8'h33, gap);
        check_val("s2 gap", gap, 1);
        recv(2, 8, "s3", 8'h34, gap);
        check_val("s3 gap", gap, 1);
`ifdef STREAM_LOOP_EN
        recv(2, 8, "s loop", 8'h31, gap);
        check_val("s loop gap", gap, 1025);
`else
        wait_low(2, 3000, n, found);
        check_val("s idle at memsize", found, 0);
`endif
      end
      begin : thread_csr
        int gap;
        repeat (3) @(posedge clk);
        #1 check_val("c edge3 q", q_bus[3], 1);
        @(posedge clk); #1 check_val("c edge4 q", q_bus[3], 0);
        recv(3, 16, "c16", 8'h5A, gap);
        @(negedge clk) rst_c = 1'b1;
        u_csr.mem[0] = 8'h01;
        u_csr.mem[1] = 8'h00;
        @(negedge clk) rst_c = 1'b0;
        recv(3, 1736, "cfb", 8'h5A, gap);
        check_val("cfb gap", gap, 3);
      end
    join
    check_val("empty never low", empty_lows, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
